// File: rtl/rom_dl_pkg.sv
// Purpose: shared types for the ROM download sequencer (FSM states, FIFO entry layout).
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rom_dl_pkg;

    localparam int DL_ADDR_W = 25;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        HOLD  = 3'd3,
        RUN   = 3'd4
    } dl_state_t;

    // One queued ROM write: core address and data byte.
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } dl_entry_t;

endpackage

// File: rtl/dl_fifo.sv
// Purpose: small synchronous FIFO of ROM write entries; head is visible combinationally on rd_dat.
// Latency: an entry pushed at an edge is readable at the head from the next cycle.
// Backpressure: push is ignored when full unless a pop happens in the same cycle (occupancy is taken after the pop).
//
// Ports: clk_sys/reset_n clock and async active-low reset; push/wr_dat enqueue; pop dequeues
// the head (rd_dat); count is current occupancy; full/empty are decoded from count.
module dl_fifo
    import rom_dl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  dl_entry_t                wr_dat,
    output dl_entry_t                rd_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    dl_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_dat  = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: it is only read while count says it holds valid data.
    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/rom_dl_ctrl.sv
// Purpose: ROM download sequencer: buffers HPS ioctl bytes and writes them into the core ROM port, holding the core in reset around the download.
// Latency: 2 cycles from ioctl_wr to dn_wr with an empty FIFO and dn_ready high (push, then registered pop).
// Backpressure: ioctl_wait asserts once occupancy reaches DEPTH-1; bytes arriving into a full FIFO are dropped and flagged in err_ovf.
//
// Ports: clk_sys/reset_n clock and async active-low reset; ioctl_* HPS download stream in, ioctl_wait out;
// dn_ready slot grant in, dn_addr/dn_data/dn_wr ROM write out; core_reset, dl_done, err_range, err_ovf, checksum status out.
module rom_dl_ctrl
    import rom_dl_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] ROM_SIZE = 16'hC000,
    parameter int          HOLD_CYC = 256
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 ioctl_download,
    input  logic                 ioctl_wr,
    input  logic [DL_ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic                 ioctl_wait,
    input  logic                 dn_ready,
    output logic [15:0]          dn_addr,
    output logic [7:0]           dn_data,
    output logic                 dn_wr,
    output logic                 core_reset,
    output logic                 dl_done,
    output logic                 err_range,
    output logic                 err_ovf,
    output logic [15:0]          checksum
);

    localparam int                CNT_W     = $clog2(DEPTH) + 1;
    localparam int                HOLD_W    = $clog2(HOLD_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]  WAIT_LVL  = CNT_W'(DEPTH - 1);

    dl_state_t         state;
    logic              dl_prev;
    logic [HOLD_W-1:0] hold_cnt;

    dl_entry_t         push_dat;
    dl_entry_t         head_dat;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    logic              in_range;
    logic              wr_load;
    logic              push;
    logic              pop;
    logic              ovf;
    logic              dl_rise;
    logic              go_load;
    logic [CNT_W-1:0]  count_nxt;

    assign in_range = (ioctl_addr < {{(DL_ADDR_W - 16){1'b0}}, ROM_SIZE});
    assign wr_load  = (state == LOAD) && ioctl_wr;
    assign pop      = !fifo_empty && dn_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push     = wr_load && in_range && (!fifo_full || pop);
    assign ovf      = wr_load && in_range && fifo_full && !pop;
    assign dl_rise  = ioctl_download && !dl_prev;
    assign push_dat = '{addr: ioctl_addr[15:0], data: ioctl_dout};
    assign count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);

    // IDLE enters LOAD on the download level (covers a download already active
    // at reset release); the other non-LOAD states need a fresh rising edge.
    assign go_load = ((state == IDLE) && ioctl_download) ||
                     (((state == FLUSH) || (state == HOLD) || (state == RUN)) && dl_rise);

    dl_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wr_dat  (push_dat),
        .rd_dat  (head_dat),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Write port and backpressure: drain the head whenever the core grants a slot.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dn_wr      <= 1'b0;
            dn_addr    <= '0;
            dn_data    <= '0;
            ioctl_wait <= 1'b0;
            dl_prev    <= 1'b0;
        end else begin
            dn_wr <= pop;
            if (pop) begin
                dn_addr <= head_dat.addr;
                dn_data <= head_dat.data;
            end
            ioctl_wait <= (count_nxt >= WAIT_LVL);
            dl_prev    <= ioctl_download;
        end
    end

    // Sequencer FSM with core reset, hold timer, checksum and sticky errors.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            core_reset <= 1'b1;
            dl_done    <= 1'b0;
            checksum   <= '0;
            err_range  <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            dl_done <= 1'b0;
            if (go_load) begin
                state      <= LOAD;
                core_reset <= 1'b1;
                checksum   <= '0;
                err_range  <= 1'b0;
                err_ovf    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // Power-on: run the same hold sequence as after a download.
                        state    <= HOLD;
                        hold_cnt <= HOLD_LOAD;
                    end
                    LOAD: begin
                        if (push)                 checksum  <= checksum + {8'h00, ioctl_dout};
                        if (wr_load && !in_range) err_range <= 1'b1;
                        if (ovf)                  err_ovf   <= 1'b1;
                        if (!ioctl_download)      state     <= FLUSH;
                    end
                    FLUSH: begin
                        // Looking at post-pop occupancy makes the cycle of the last
                        // write the first hold cycle.
                        if (count_nxt == '0) begin
                            state    <= HOLD;
                            hold_cnt <= HOLD_LOAD;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt == '0) begin
                            state      <= RUN;
                            core_reset <= 1'b0;
                            dl_done    <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end
                    end
                    RUN: begin
                        core_reset <= 1'b0;
                    end
                    default: begin
                        state      <= IDLE;
                        core_reset <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
